// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-2 packet demultiplexer.
// Holds the routing FSM encoding, the statistics counter width and the
// helper that resolves which channel the current upstream beat targets.
package demux_pkg;

  // Routing state: IDLE follows sel_in, LOCK_x pins the rest of a packet.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } state_t;

  // Width of the optional per-channel transfer counters.
  localparam int CNT_W = 16;

  // Channel indices used for the output slot array.
  localparam int CH_A = 0;
  localparam int CH_B = 1;

  // Destination of an upstream beat: 0 -> A, 1 -> B.
  // In a locked state sel_in is ignored so a packet never splits.
  function automatic logic route_dest(state_t state, logic sel);
    logic dest;
    case (state)
      LOCK_A:  dest = 1'b0;
      LOCK_B:  dest = 1'b1;
      default: dest = sel;
    endcase
    return dest;
  endfunction

endpackage

// File: rtl/demux_1_2_out_slot.sv
// One-entry valid/ready output register (module out_slot).
// Loads when the steering logic says so, holds its contents stable while
// the consumer stalls, and supports drain-and-reload in the same cycle so
// a channel can sustain one beat per clock.
module out_slot #(
  parameter int WIDTH = 9
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             load_in,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ready_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             space_out
);

  logic [WIDTH-1:0] data_reg;
  logic             valid_reg;

  // Room for a new beat when empty or when the current one leaves this cycle.
  assign space_out = ~valid_reg | ready_in;
  assign data_out  = data_reg;
  assign valid_out = valid_reg;

  // Register update: load wins over drain, data only changes on load.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else begin
      if (load_in) begin
        valid_reg <= 1'b1;
        data_reg  <= data_in;
      end else if (ready_in) begin
        valid_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/demux_1_2.sv
// 1-to-2 packet demultiplexer with valid/ready handshakes.
// The first beat of a packet is routed by sel_in; a routing FSM then locks
// the remaining beats onto the same channel until last_in is accepted.
// Optional feature: define DEMUX_1_2_STATS_EN to add 16-bit per-channel
// downstream transfer counters (a_cnt_out, b_cnt_out).
module demux_1_2
  import demux_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic [DATA_W-1:0] a_in,
  input  logic              sel_in,
  input  logic              last_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic [DATA_W-1:0] ya_out,
  output logic [DATA_W-1:0] yb_out,
  output logic              ya_last_out,
  output logic              yb_last_out,
  output logic              ya_valid_out,
  output logic              yb_valid_out,
  input  logic              ya_ready_in,
  input  logic              yb_ready_in
`ifdef DEMUX_1_2_STATS_EN
  ,
  output logic [CNT_W-1:0]  a_cnt_out,
  output logic [CNT_W-1:0]  b_cnt_out
`endif
);

  state_t          state_reg;
  logic            dest;
  logic            up_fire;

  logic [1:0]      slot_load;
  logic [1:0]      slot_ready;
  logic [1:0]      slot_valid;
  logic [1:0]      slot_space;
  logic [DATA_W:0] slot_data [2];
  logic [DATA_W:0] beat_data;

  // Destination depends only on state and sel_in, never on valid_in.
  assign dest      = route_dest(state_reg, sel_in);
  assign ready_out = rst_n_in & slot_space[dest];
  assign up_fire   = valid_in & ready_out;
  assign beat_data = {last_in, a_in};

  assign slot_ready[CH_A] = ya_ready_in;
  assign slot_ready[CH_B] = yb_ready_in;

  // Only the destination slot sees a load; the other channel is untouched.
  assign slot_load[CH_A] = up_fire & ~dest;
  assign slot_load[CH_B] = up_fire &  dest;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      out_slot #(
        .WIDTH (DATA_W + 1)
      ) u_slot (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .load_in   (slot_load[gi]),
        .data_in   (beat_data),
        .ready_in  (slot_ready[gi]),
        .data_out  (slot_data[gi]),
        .valid_out (slot_valid[gi]),
        .space_out (slot_space[gi])
      );
    end
  endgenerate

  assign ya_out       = slot_data[CH_A][DATA_W-1:0];
  assign ya_last_out  = slot_data[CH_A][DATA_W];
  assign ya_valid_out = slot_valid[CH_A];
  assign yb_out       = slot_data[CH_B][DATA_W-1:0];
  assign yb_last_out  = slot_data[CH_B][DATA_W];
  assign yb_valid_out = slot_valid[CH_B];

  // Routing FSM: advances only on an accepted upstream beat.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_reg <= IDLE;
    end else if (up_fire) begin
      case (state_reg)
        IDLE: begin
          if (!last_in) begin
            state_reg <= sel_in ? LOCK_B : LOCK_A;
          end
        end
        LOCK_A, LOCK_B: begin
          if (last_in) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef DEMUX_1_2_STATS_EN
  logic [CNT_W-1:0] cnt_reg [2];

  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      // Count downstream transfers; natural wrap from all-ones to zero.
      always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
          cnt_reg[gi] <= '0;
        end else if (slot_valid[gi] & slot_ready[gi]) begin
          cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
        end
      end
    end
  endgenerate

  assign a_cnt_out = cnt_reg[CH_A];
  assign b_cnt_out = cnt_reg[CH_B];
`endif

endmodule
